// File: rtl/prog_timer_if.sv
// Control/status bundle between a control FSM (master) and the programmable
// interval timer (slave).
interface prog_timer_if #(
    parameter int CNT_W = 21,
    parameter int PRE_W = 8
);
    logic             CLR;
    logic             START;
    logic             HOLD;
    logic             MODE;
    logic [CNT_W-1:0] PERIOD;
    logic [PRE_W-1:0] PRESCALE;
    logic             PULSE;
    logic             BUSY;
    logic [CNT_W-1:0] COUNT;

    modport master (
        output CLR, START, HOLD, MODE, PERIOD, PRESCALE,
        input  PULSE, BUSY, COUNT
    );

    modport slave (
        input  CLR, START, HOLD, MODE, PERIOD, PRESCALE,
        output PULSE, BUSY, COUNT
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable-period interval timer with prescaler, one-shot/periodic modes,
// pause, restart-on-START and a single-cycle registered expiry strobe.
module prog_timer #(
    parameter int CNT_W = 21,
    parameter int PRE_W = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    prog_timer_if.slave   tmr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01
    } state_e;

    state_e           state_q,  state_d;
    logic [PRE_W-1:0] pre_q,    pre_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] per_l_q,  per_l_d;
    logic [PRE_W-1:0] pre_l_q,  pre_l_d;
    logic             mode_l_q, mode_l_d;
    logic             pulse_q,  pulse_d;
    logic             busy_q,   busy_d;

    // Next-state logic: CLR > START > HOLD > prescaled counting.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        count_d  = count_q;
        per_l_d  = per_l_q;
        pre_l_d  = pre_l_q;
        mode_l_d = mode_l_q;
        pulse_d  = 1'b0;

        if (tmr.CLR) begin
            state_d  = ST_IDLE;
            pre_d    = '0;
            count_d  = '0;
            per_l_d  = '0;
            pre_l_d  = '0;
            mode_l_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tmr.START) begin
                        per_l_d  = tmr.PERIOD;
                        pre_l_d  = tmr.PRESCALE;
                        mode_l_d = tmr.MODE;
                        pre_d    = '0;
                        count_d  = '0;
                        state_d  = ST_RUN;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A restart wins over a coincident terminal tick.
                    if (tmr.START) begin
                        per_l_d  = tmr.PERIOD;
                        pre_l_d  = tmr.PRESCALE;
                        mode_l_d = tmr.MODE;
                        pre_d    = '0;
                        count_d  = '0;
                    end else if (tmr.HOLD) begin
                        pre_d    = pre_q;
                    end else if (pre_q == pre_l_q) begin
                        pre_d = '0;
                        if (count_q == per_l_q) begin
                            count_d = '0;
                            pulse_d = 1'b1;
                            if (mode_l_q) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            count_q  <= '0;
            per_l_q  <= '0;
            pre_l_q  <= '0;
            mode_l_q <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            count_q  <= count_d;
            per_l_q  <= per_l_d;
            pre_l_q  <= pre_l_d;
            mode_l_q <= mode_l_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
        end
    end

    assign tmr.PULSE = pulse_q;
    assign tmr.BUSY  = busy_q;
    assign tmr.COUNT = count_q;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios plus randomized
// traffic compared every cycle against an elapsed-time reference model.
module tb_prog_timer;

    logic CLK;
    logic RST_N;

    prog_timer_if #(.CNT_W(21), .PRE_W(8)) tif ();
    prog_timer_if #(.CNT_W(12), .PRE_W(8)) sif ();

    prog_timer #(.CNT_W(21), .PRE_W(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tmr   (tif.slave)
    );

    // Narrow instance so the all-ones period boundary fits the cycle budget.
    prog_timer #(.CNT_W(12), .PRE_W(8)) dut_s (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tmr   (sif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ref_cyc = 0;

    // Reference model: elapsed enabled cycles since START within one interval.
    bit     m_run   = 1'b0;
    bit     m_mode  = 1'b0;
    longint m_e     = 0;
    longint m_n     = 0;
    longint m_p     = 0;
    bit     e_pulse = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_update();
        e_pulse = 1'b0;
        if (!RST_N || tif.CLR) begin
            m_run = 1'b0; m_e = 0; m_n = 0; m_p = 0; m_mode = 1'b0;
        end else if (tif.START) begin
            m_run  = 1'b1;
            m_e    = 0;
            m_n    = longint'(tif.PERIOD);
            m_p    = longint'(tif.PRESCALE);
            m_mode = tif.MODE;
        end else if (m_run && !tif.HOLD) begin
            m_e++;
            if (m_e == (m_n + 1) * (m_p + 1)) begin
                e_pulse = 1'b1;
                m_e     = 0;
                if (!m_mode) m_run = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        cyc++;
        #1;
        check_eq("pulse", tif.PULSE, e_pulse);
        check_eq("busy",  tif.BUSY,  m_run);
        check_eq("count", tif.COUNT, m_e / (m_p + 1));
    endtask

    task automatic start(input int n, input int p, input bit mode);
        tif.PERIOD   = 21'(n);
        tif.PRESCALE = 8'(p);
        tif.MODE     = mode;
        tif.START    = 1'b1;
        step();
        ref_cyc   = cyc;
        tif.START = 1'b0;
    endtask

    task automatic wait_pulse(input string tag, input int exp_lat);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tif.PULSE && n < 400);
        check_eq(tag, cyc - ref_cyc, exp_lat);
    endtask

    task automatic wait_count(input int v);
        int n = 0;
        while (tif.COUNT != 21'(v) && n < 400) begin
            step();
            n++;
        end
    endtask

    initial begin
        RST_N = 1'b0;
        tif.CLR = 1'b0; tif.START = 1'b0; tif.HOLD = 1'b0; tif.MODE = 1'b0;
        tif.PERIOD = '0; tif.PRESCALE = '0;
        sif.CLR = 1'b0; sif.START = 1'b0; sif.HOLD = 1'b0; sif.MODE = 1'b0;
        sif.PERIOD = '0; sif.PRESCALE = '0;
        repeat (2) step();
        check_eq("rst_busy",  tif.BUSY,  1'b0);
        check_eq("rst_count", tif.COUNT, 21'd0);
        RST_N = 1'b1;
        step();

        // One-shot basic.
        start(3, 0, 1'b0);
        wait_pulse("oneshot_lat", 4);
        check_eq("oneshot_busy", tif.BUSY, 1'b0);
        repeat (6) step();

        // Periodic with prescale, then mid-run CLR.
        start(2, 4, 1'b1);
        wait_pulse("per_lat1", 15);
        wait_pulse("per_lat2", 30);
        wait_pulse("per_lat3", 45);
        check_eq("per_busy", tif.BUSY, 1'b1);
        repeat (4) step();
        tif.CLR = 1'b1;
        step();
        tif.CLR = 1'b0;
        check_eq("clr_busy",  tif.BUSY,  1'b0);
        check_eq("clr_count", tif.COUNT, 21'd0);
        repeat (3) step();

        // Hold freezes the count.
        start(5, 1, 1'b0);
        wait_count(2);
        tif.HOLD = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("hold_count", tif.COUNT, 21'd2);
        end
        tif.HOLD = 1'b0;
        wait_pulse("hold_lat", 19);

        // Restart mid-count.
        start(6, 0, 1'b0);
        wait_count(4);
        start(6, 0, 1'b0);
        check_eq("restart_count", tif.COUNT, 21'd0);
        wait_pulse("restart_lat", 7);

        // START coincident with the terminal tick.
        start(6, 0, 1'b0);
        wait_count(6);
        start(6, 0, 1'b0);
        check_eq("coll_pulse", tif.PULSE, 1'b0);
        wait_pulse("coll_lat", 7);

        // N = 0, P = 0 periodic: continuous pulse.
        start(0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("cont_pulse", tif.PULSE, 1'b1);
        end
        tif.CLR = 1'b1;
        step();
        tif.CLR = 1'b0;

        // PERIOD change mid-run is ignored.
        start(4, 1, 1'b0);
        repeat (2) step();
        tif.PERIOD = 21'd1;
        wait_pulse("perchg_lat", 10);

        // Reset mid-run.
        start(9, 0, 1'b1);
        repeat (3) step();
        RST_N = 1'b0;
        step();
        check_eq("rstmid_pulse", tif.PULSE, 1'b0);
        check_eq("rstmid_busy",  tif.BUSY,  1'b0);
        check_eq("rstmid_count", tif.COUNT, 21'd0);
        RST_N = 1'b1;

        // Reset glitch between edges has no effect.
        start(5, 0, 1'b0);
        repeat (2) step();
        #2 RST_N = 1'b0;
        #2 RST_N = 1'b1;
        wait_pulse("glitch_lat", 6);

        // All-ones period on the narrow instance.
        begin
            int s_ref;
            int n;
            sif.PERIOD = 12'hFFF; sif.PRESCALE = 8'd0; sif.MODE = 1'b0; sif.START = 1'b1;
            step();
            s_ref = cyc;
            sif.START = 1'b0;
            repeat (100) step();
            check_eq("maxn_count", sif.COUNT, 12'd100);
            check_eq("maxn_busy1", sif.BUSY, 1'b1);
            n = 0;
            do begin
                step();
                n++;
            end while (!sif.PULSE && n < 5000);
            check_eq("maxn_lat",   cyc - s_ref, 4096);
            check_eq("maxn_busy0", sif.BUSY, 1'b0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tif.START    = ($urandom % 16) == 0;
            tif.HOLD     = ($urandom % 4) == 0;
            tif.CLR      = ($urandom % 64) == 0;
            RST_N        = ($urandom % 200) != 0;
            tif.MODE     = 1'($urandom);
            tif.PERIOD   = 21'($urandom % 8);
            tif.PRESCALE = 8'($urandom % 4);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
